// File: rtl/uart_rx_cfg_if.sv
// Receive-side read bus for uart_rx_cfg.
// Ports (as seen from the receiver, modport slave):
//   rd_en   in   pop the FIFO head
//   rdata   out  FIFO head, valid while rx_rdy=1
//   rx_rdy  out  FIFO not empty
// The master modport is the consumer side.
interface uart_rx_cfg_if #(
   parameter int DATA_W = 8
);
   logic              rd_en;
   logic [DATA_W-1:0] rdata;
   logic              rx_rdy;

   modport master (output rd_en, input rdata, input rx_rdy);
   modport slave  (input rd_en, output rdata, output rx_rdy);
endinterface

// File: rtl/uart_rx_cfg.sv
// UART receiver with a small receive FIFO and sticky error flags.
// Optional feature macro: UART_RX_PARITY_EN adds a parity bit after the data
// bits (even parity by default, odd when PARITY_ODD=1). Without it the frame
// is start + DATA_W data + stop and parity_err is tied low.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   RX           asynchronous serial line, idle high
//   err_clr      clear all sticky error flags
//   rd_bus       read bus (rd_en / rdata / rx_rdy), see uart_rx_cfg_if
//   busy         receiver is inside a frame
//   frame_err    sticky, stop bit sampled low
//   overrun      sticky, good frame arrived while FIFO full
//   parity_err   sticky, parity mismatch
//
// state    | meaning
// S_IDLE   | waiting for synchronized RX low
// S_START  | half a bit in, confirm the start bit
// S_DATA   | sampling DATA_W bits, LSB first
// S_PARITY | sampling parity bit (UART_RX_PARITY_EN only)
// S_STOP   | sampling stop bit, push or flag, then back to idle
module uart_rx_cfg #(
   parameter int DATA_W     = 8,
   parameter int BAUD_DIV   = 2604,
   parameter int FIFO_DEPTH = 4,
   parameter int PARITY_ODD = 0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         RX,
   input  logic         err_clr,
   uart_rx_cfg_if.slave rd_bus,
   output logic         busy,
   output logic         frame_err,
   output logic         overrun,
   output logic         parity_err
);
   localparam int CW = $clog2(BAUD_DIV);
   localparam int BW = $clog2(DATA_W);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [CW-1:0] CNT_HALF = CW'(BAUD_DIV / 2 - 1);
   localparam logic [CW-1:0] CNT_FULL = CW'(BAUD_DIV - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);
   localparam logic [AW:0]   DEPTH_V  = (AW + 1)'(FIFO_DEPTH);

`ifdef UART_RX_PARITY_EN
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

   state_t            state;
   logic              rx_s1, rx_s2;
   logic [CW-1:0]     cnt;
   logic [BW-1:0]     bit_idx;
   logic [DATA_W-1:0] shreg;
   logic              par_bad;
   logic              tc;

   logic [DATA_W-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]     rd_ptr, wr_ptr;
   logic [AW:0]       count, count_nxt;
   logic              rx_rdy_q;
   logic              push, full, do_pop, do_wr, ovr_set, fe_set;

   assign tc      = (cnt == '0);
   assign push    = (state == S_STOP) && tc && rx_s2 && !par_bad;
   assign fe_set  = (state == S_STOP) && tc && !rx_s2;
   assign full    = (count == DEPTH_V);
   assign do_pop  = rd_bus.rd_en && (count != '0);
   // A full FIFO still accepts the word when a pop frees the head in the same cycle.
   assign do_wr   = push && (!full || do_pop);
   assign ovr_set = push && full && !rd_bus.rd_en;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_s1 <= 1'b1;
         rx_s2 <= 1'b1;
      end else begin
         rx_s1 <= RX;
         rx_s2 <= rx_s1;
      end
   end

`ifdef UART_RX_PARITY_EN
   localparam logic PAR_ODD = (PARITY_ODD != 0);
   logic par_mis;
   assign par_mis = (^shreg) ^ rx_s2 ^ PAR_ODD;
`else
   logic unused_par_odd;
   assign unused_par_odd = (PARITY_ODD != 0);
   assign par_bad        = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         cnt     <= '0;
         bit_idx <= '0;
         shreg   <= '0;
         busy    <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bad <= 1'b0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if (!rx_s2) begin
                  state <= S_START;
                  cnt   <= CNT_HALF;
                  busy  <= 1'b1;
               end
            end
            S_START: begin
               if (tc) begin
                  if (rx_s2) begin
                     state <= S_IDLE;
                     busy  <= 1'b0;
                  end else begin
                     state   <= S_DATA;
                     cnt     <= CNT_FULL;
                     bit_idx <= '0;
`ifdef UART_RX_PARITY_EN
                     par_bad <= 1'b0;
`endif
                  end
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            S_DATA: begin
               if (tc) begin
                  shreg   <= {rx_s2, shreg[DATA_W-1:1]};
                  cnt     <= CNT_FULL;
                  bit_idx <= bit_idx + BW'(1);
                  if (bit_idx == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                     state <= S_PARITY;
`else
                     state <= S_STOP;
`endif
                  end
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
               if (tc) begin
                  par_bad <= par_mis;
                  cnt     <= CNT_FULL;
                  state   <= S_STOP;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
`endif
            S_STOP: begin
               // Leave at the sample point so a back-to-back start bit is not missed.
               if (tc) begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      count_nxt = count;
      case ({do_wr, do_pop})
         2'b10:   count_nxt = count + (AW + 1)'(1);
         2'b01:   count_nxt = count - (AW + 1)'(1);
         default: count_nxt = count;
      endcase
   end

   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr] <= shreg;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         rx_rdy_q <= 1'b0;
      end else begin
         if (do_pop) rd_ptr <= rd_ptr + AW'(1);
         if (do_wr)  wr_ptr <= wr_ptr + AW'(1);
         count    <= count_nxt;
         rx_rdy_q <= (count_nxt != '0);
      end
   end

   assign rd_bus.rx_rdy = rx_rdy_q;
   // Head is forced to zero while empty so rdata is clean out of reset.
   assign rd_bus.rdata  = rx_rdy_q ? mem[rd_ptr] : '0;

   // Set events take priority over a same-cycle err_clr.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         if (fe_set)       frame_err <= 1'b1;
         else if (err_clr) frame_err <= 1'b0;
         if (ovr_set)      overrun <= 1'b1;
         else if (err_clr) overrun <= 1'b0;
      end
   end

`ifdef UART_RX_PARITY_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                     parity_err <= 1'b0;
      else if ((state == S_PARITY) && tc && par_mis)  parity_err <= 1'b1;
      else if (err_clr)                               parity_err <= 1'b0;
   end
`else
   assign parity_err = 1'b0;
`endif
endmodule

// File: doc/uart_rx_cfg.md
UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 Parameter DATA_W, default 8, data bits per frame (5..9).
REQ-002 Parameter BAUD_DIV, default 2604, clk cycles per bit (>= 4).
REQ-003 Parameter FIFO_DEPTH, default 4, receive FIFO entries (power of 2, >= 2).
REQ-004 Parameter PARITY_ODD, default 0; 0 selects even parity, 1 selects odd; used only under UART_RX_PARITY_EN.
REQ-005 clk  input  1  clock; all state on posedge clk.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 RX  input  1  asynchronous serial line, idle high.
REQ-008 rd_en  input  1  pop FIFO head.
REQ-009 err_clr  input  1  clear all sticky error flags.
REQ-010 rdata  output  DATA_W  FIFO head; valid while rx_rdy=1.
REQ-011 rx_rdy  output  1  FIFO not empty.
REQ-012 busy  output  1  high in any state other than IDLE.
REQ-013 frame_err  output  1  sticky; stop bit sampled low.
REQ-014 overrun  output  1  sticky; good frame arrived while FIFO full.
REQ-015 parity_err  output  1  sticky; parity mismatch (port always present).

Function
REQ-016 RX SHALL pass through a 2-flop posedge synchronizer; all decisions use the synchronized value.
REQ-017 FSM states SHALL be IDLE, START, DATA, PARITY (only when UART_RX_PARITY_EN is defined), STOP.
REQ-018 IDLE: synchronized RX=0 -> START, bit counter loaded with BAUD_DIV/2-1.
REQ-019 Bit counter width SHALL be $clog2(BAUD_DIV); it decrements every cycle outside IDLE; a sample occurs when it equals 0.
REQ-020 START sample: RX=1 -> false start, return to IDLE with no flag; RX=0 -> DATA, counter reloaded with BAUD_DIV-1.
REQ-021 DATA: DATA_W samples shifted in LSB first, counter reloaded with BAUD_DIV-1 after each sample; after the last sample -> PARITY or STOP.
REQ-022 STOP sample: RX=0 -> frame_err set, word discarded; RX=1 -> word pushed; in either case -> IDLE in the next cycle, with no wait for the end of the stop bit.
REQ-023 rx_rdy SHALL rise on the cycle after the STOP sample that pushes into an empty FIFO.
REQ-024 Push with FIFO full and rd_en=0: overrun set; word dropped; FIFO contents unchanged.
REQ-025 Push with FIFO full and rd_en=1 in the same cycle: pop and push both occur; no overrun.
REQ-026 rd_en with FIFO empty SHALL be ignored; pointers wrap modulo FIFO_DEPTH.
REQ-027 err_clr clears all sticky flags; a flag set event in the same cycle wins.
REQ-028 A new start bit SHALL be accepted in IDLE regardless of FIFO or error state.

Reset
REQ-029 rst_n low SHALL force: state IDLE, synchronizer flops 1, FIFO empty, rx_rdy 0, busy 0, all error flags 0, rdata 0.
REQ-030 Reset mid-frame SHALL abandon the frame; after release a full new start bit is required.

Configuration
REQ-031 Macro UART_RX_PARITY_EN defined: the PARITY state samples one bit after the data bits; if the XOR of the data bits, PARITY_ODD and the parity bit is nonzero, parity_err is set and the word is discarded; STOP is still sampled.
REQ-032 UART_RX_PARITY_EN undefined: no PARITY state; the frame is start+DATA_W+stop; parity_err is tied 0.

Verification
REQ-033 BAUD_DIV=16, DATA_W=8: send 0xA5 -> rdata=0xA5, rx_rdy=1 exactly one cycle after the stop sample; rd_en -> rx_rdy=0.
REQ-034 RX low pulse of 6 cycles then high -> no push, no flag, busy returns 0.
REQ-035 Frame 0x3C with stop bit low -> frame_err=1, FIFO empty; err_clr -> frame_err=0.
REQ-036 FIFO_DEPTH=4: 5 back-to-back frames 0x01..0x05 with no reads -> overrun=1; reads return 0x01..0x04; repeat with rd_en coincident with the 5th push -> overrun stays 0.
REQ-037 UART_RX_PARITY_EN, PARITY_ODD=0: 0x07 with parity bit 1 -> accepted; with parity bit 0 -> parity_err=1, no push.
REQ-038 rst_n asserted during the data bit 4 sample of 0xFF -> all outputs at reset values; next frame 0x55 -> rdata=0x55.
